pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the program counter of the MIPS-32 datapath and sequences instruction fetch.
//   Selects the next PC from PC+4, branch target or jump target, and issues req/ack fetches to instruction memory.
//   Sits between control unit / branch compare and the instruction memory port; presents one valid instruction slot per fetch.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//   EXC_VECTOR    32'h0000_0180  redirect target on misaligned JR (used only with PC_ALIGN_CHECK_EN)
// PORTS
//   clk           in   1   single clock, rising edge
//   rst_n         in   1   asynchronous, active-low reset
//   imem_req      out  1   fetch request, held until imem_ack
//   imem_addr     out  32  fetch address (= pc)
//   imem_ack      in   1   fetch complete; instruction available this cycle
//   instr_valid   out  1   current instruction slot is executing
//   pc            out  32  PC of current instruction
//   branch_taken  in   1   conditional branch resolved taken (sampled in S_EXEC)
//   branch_imm    in   16  branch offset, word units, signed
//   jump          in   1   J/JAL
//   jump_index    in   26  J-format instr_index
//   jump_reg      in   1   JR/JALR
//   jr_target     in   32  register-sourced target
//   stall         in   1   hold current instruction, no PC update
//   halt          in   1   stop fetching after current instruction
//   halted        out  1   sequencer parked in S_HALT
//   misalign_err  out  1   1-cycle pulse, misaligned JR (constant 0 without macro)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=S_RESET, pc=RESET_VECTOR; imem_req, instr_valid, halted, misalign_err = 0.
//   FSM: S_RESET -> S_FETCH (first clk after rst_n=1).
//     S_FETCH: imem_req=1, imem_addr=pc; on imem_ack -> S_EXEC.
//     S_EXEC: instr_valid=1. stall=1: stay, pc unchanged, redirect inputs ignored.
//       stall=0: pc<=next_pc; halt=1 -> S_HALT else -> S_FETCH.
//     S_HALT: halted=1, imem_req=0, pc frozen; exit only via reset.
//   Fetch latency: min 2 cycles/instruction (FETCH with same-cycle ack + EXEC).
//   next_pc priority: jump_reg > jump > branch_taken > pc+4.
//     pcp4 = pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
//     branch: pcp4 + {{14{imm[15]}}, imm, 2'b00}, mod 2^32.
//     jump: {pcp4[31:28], jump_index, 2'b00}.
//     jump_reg: jr_target (alignment per CONFIGURATION).
//   halt with redirect, same cycle: pc takes redirect target, then S_HALT.
//   imem_ack outside S_FETCH: ignored. imem_addr stable while imem_req=1.
//   Reset mid-fetch: imem_req drops immediately (async); later ack for the aborted fetch is ignored.
//   instr_valid and imem_req are never both 1.
// CONFIGURATION
//   PC_ALIGN_CHECK_EN defined: jump_reg with jr_target[1:0]!=0 -> pc<=EXC_VECTOR,
//     misalign_err=1 for exactly one cycle (the cycle after the S_EXEC update), then normal fetch.
//   Undefined: jr_target[1:0] forced to 2'b00; misalign_err tied 0. Port list identical in both builds.
// STRUCTURE
//   Shared header pc_seq_defs.vh: state encodings (S_RESET, S_FETCH, S_EXEC, S_HALT; 2-bit),
//     default RESET_VECTOR / EXC_VECTOR constants, PC_INC = 32'd4.
//   Sub-module next_pc_calc (combinational): pc, redirect inputs -> next_pc, misalign flag.
//   Top holds FSM, pc register, and output registers.
// TESTING
//   Reset release, imem_ack tied 1 -> addresses 0x0,0x4,0x8 on imem_req; instr_valid alternates with imem_req.
//   pc=0x0040_0010, branch_taken, imm=16'hFFFC -> next pc 0x0040_0004; imm=16'h0003 -> 0x0040_0020.
//   pc=0x1000_0000, jump, index=26'h000_0040 -> pc 0x1000_0100; jump+branch_taken together -> jump wins.
//   stall=1 for 3 cycles in S_EXEC -> pc and instr_valid held, no imem_req; release -> single advance.
//   rst_n low during S_FETCH with ack 1 cycle later -> imem_req 0 at once, pc=RESET_VECTOR, ack ignored.
//   jump_reg, jr_target=0x0000_1002 -> with macro pc=EXC_VECTOR + 1-cycle misalign_err; without, pc=0x0000_1000.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// default vectors and the sequential PC increment.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Word-unit signed branch offset to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jump_reg > jump > branch_taken > pc+4.
// Alignment handling of register-sourced targets depends on PC_ALIGN_CHECK_EN.
module next_pc_calc
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] pcp4;
    logic [31:0] jr_pc;
    logic        jr_bad;

    assign pcp4 = pc + PC_INC;

`ifdef PC_ALIGN_CHECK_EN
    assign jr_bad = |jr_target[1:0];
    assign jr_pc  = jr_bad ? EXC_VECTOR : jr_target;
`else
    // Low target bits are discarded; keep them and the vector visibly consumed.
    logic        unused_jr_lsb;
    logic [31:0] unused_exc_vector;
    assign unused_jr_lsb     = ^jr_target[1:0];
    assign unused_exc_vector = EXC_VECTOR;
    assign jr_bad            = 1'b0;
    assign jr_pc             = {jr_target[31:2], 2'b00};
`endif

    // Priority mux over the redirect sources.
    always_comb begin
        next_pc  = pcp4;
        misalign = 1'b0;
        if (jump_reg) begin
            next_pc  = jr_pc;
            misalign = jr_bad;
        end else if (jump) begin
            next_pc = {pcp4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pcp4 + branch_offset(branch_imm);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the MIPS-32 datapath.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned JR redirects to EXC_VECTOR
// and pulses misalign_err); without it JR targets are word-aligned silently.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic        stall,
    input  logic        halt,
    output logic        halted,
    output logic        misalign_err
);

    pc_state_t   state;
    logic [31:0] next_pc;
    logic        misalign;

    next_pc_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_calc (
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_target    (jr_target),
        .next_pc      (next_pc),
        .misalign     (misalign)
    );

    // pc only changes when leaving S_EXEC, so the address is stable while requesting.
    assign imem_addr = pc;

    // Fetch/execute sequencing with registered outputs; misalign_err defaults low
    // every cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RESET;
            pc           <= RESET_VECTOR;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state       <= S_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc           <= next_pc;
                        misalign_err <= misalign;
                        instr_valid  <= 1'b0;
                        if (halt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic [31:0] pc;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic        stall;
    logic        halt;
    logic        halted;
    logic        misalign_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0180)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_target    (jr_target),
        .stall        (stall),
        .halt         (halt),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        branch_taken = 1'b0;
        branch_imm   = '0;
        jump         = 1'b0;
        jump_index   = '0;
        jump_reg     = 1'b0;
        jr_target    = '0;
        halt         = 1'b0;
        stall        = 1'b0;
    endtask

    // Advance until an instruction slot is executing; a timeout is a failed check.
    task automatic wait_exec();
        int unsigned n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        if (!instr_valid) check("wait_exec_timeout", 32'd0, 32'd1);
    endtask

    // Execute one instruction with the given redirect inputs, then drop them.
    task automatic do_exec(input logic bt, input logic [15:0] imm, input logic j,
                           input logic [25:0] idx, input logic jr, input logic [31:0] jrt,
                           input logic hlt);
        wait_exec();
        branch_taken = bt;
        branch_imm   = imm;
        jump         = j;
        jump_index   = idx;
        jump_reg     = jr;
        jr_target    = jrt;
        halt         = hlt;
        step();
        clear_redirects();
    endtask

    initial begin
        logic [31:0] pc0;
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        clear_redirects();

        #2;
        check("rst_req",      {31'd0, imem_req},     32'd0);
        check("rst_valid",    {31'd0, instr_valid},  32'd0);
        check("rst_halted",   {31'd0, halted},       32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_pc",       pc,                    32'h0000_0000);

        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ack tied high: FETCH/EXEC alternate, addresses 0,4,8.
        for (int i = 0; i < 3; i++) begin
            check("seq_req",   {31'd0, imem_req},    32'd1);
            check("seq_valid", {31'd0, instr_valid}, 32'd0);
            check("seq_addr",  imem_addr,            32'(4 * i));
            step();
            check("seq_exec_req",   {31'd0, imem_req},    32'd0);
            check("seq_exec_valid", {31'd0, instr_valid}, 32'd1);
            check("seq_exec_pc",    pc,                   32'(4 * i));
            if (i < 2) step();
        end

        // Branches from 0x0040_0010.
        do_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h0040_0010, 1'b0);
        check("jr_to_400010", pc, 32'h0040_0010);
        do_exec(1'b1, 16'hFFFC, 1'b0, '0, 1'b0, '0, 1'b0);
        check("branch_neg", pc, 32'h0040_0004);
        do_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h0040_0010, 1'b0);
        do_exec(1'b1, 16'h0003, 1'b0, '0, 1'b0, '0, 1'b0);
        check("branch_pos", pc, 32'h0040_0020);

        // Jumps from 0x1000_0000.
        do_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h1000_0000, 1'b0);
        do_exec(1'b0, '0, 1'b1, 26'h000_0040, 1'b0, '0, 1'b0);
        check("jump", pc, 32'h1000_0100);
        do_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h1000_0000, 1'b0);
        do_exec(1'b1, 16'h0003, 1'b1, 26'h000_0040, 1'b0, '0, 1'b0);
        check("jump_over_branch", pc, 32'h1000_0100);

        // Stall holds the slot for 3 cycles, redirect inputs ignored.
        wait_exec();
        pc0          = pc;
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_imm   = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",    pc,                   pc0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_req",   {31'd0, imem_req},    32'd0);
        end
        clear_redirects();
        step();
        check("stall_release_pc",  pc,                 pc0 + 32'd4);
        check("stall_release_req", {31'd0, imem_req},  32'd1);

        // PC+4 wraps at the top of the address space.
        do_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        do_exec(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        check("pc_wrap", pc, 32'h0000_0000);

        // Misaligned register target.
        do_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_1002, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("jr_misalign_pc",    pc,                    32'h0000_0180);
        check("jr_misalign_pulse", {31'd0, misalign_err}, 32'd1);
`else
        check("jr_misalign_pc",    pc,                    32'h0000_1000);
        check("jr_misalign_pulse", {31'd0, misalign_err}, 32'd0);
`endif
        step();
        check("misalign_pulse_end", {31'd0, misalign_err}, 32'd0);

        // Reset in the middle of a fetch; a late ack must not start execution.
        do_exec(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midfetch_req", {31'd0, imem_req}, 32'd0);
        check("midfetch_pc",  pc,                32'h0000_0000);
        #1 rst_n = 1'b1;
        imem_ack = 1'b1;
        step();
        check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("late_ack_req",   {31'd0, imem_req},    32'd1);
        check("late_ack_addr",  imem_addr,            32'h0000_0000);

        // Halt together with a redirect: target taken, then parked.
        do_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_2000, 1'b1);
        check("halt_pc",     pc,                   32'h0000_2000);
        check("halt_flag",   {31'd0, halted},      32'd1);
        check("halt_valid",  {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_hold_req", {31'd0, imem_req}, 32'd0);
            check("halt_hold_pc",  pc,                32'h0000_2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
